// File: rtl/host_cmd_hub.sv
// Host command hub: parses 10-byte host request frames, drives the capture core
// command/argument interface, and returns a 10-byte response frame.
module host_cmd_hub #(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  RESP_OK     = 8'h5A,
  parameter logic [7:0]  RESP_TMO    = 8'hE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] command,
  output logic       commandStrobe,
  output logic [7:0] regIn0,
  output logic [7:0] regIn1,
  output logic [7:0] regIn2,
  output logic [7:0] regIn3,
  output logic [7:0] regIn4,
  output logic [7:0] regIn5,
  output logic [7:0] regIn6,
  output logic [7:0] regIn7,
  input  logic [7:0] regOut0,
  input  logic [7:0] regOut1,
  input  logic [7:0] regOut2,
  input  logic [7:0] regOut3,
  input  logic [7:0] regOut4,
  input  logic [7:0] regOut5,
  input  logic [7:0] regOut6,
  input  logic [7:0] regOut7,
  input  logic [7:0] status
);

  localparam int unsigned CW      = $clog2(ACK_TIMEOUT) + 1;
  localparam int unsigned NRESP   = 10;
  localparam int unsigned NARG    = 8;
  localparam logic [7:0]  ACK_CMD = 8'h08;
  localparam logic [7:0]  NOP_OP  = 8'h00;

  typedef enum logic [2:0] {
    IDLE, GET_OP, GET_ARG, STROBE, WAIT_ACK, ACK_STROBE, RESP
  } state_t;

  state_t        state, state_d;
  logic [7:0]    opcode, opcode_d;
  logic [2:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    tx_idx, tx_idx_d;
  logic [7:0]    resp [NRESP];
  logic [7:0]    resp_d [NRESP];
  logic [7:0]    reg_in [NARG];
  logic [7:0]    reg_in_d [NARG];
  logic [7:0]    reg_out [NARG];
  logic [7:0]    command_d, tx_data_d, hdr;
  logic          strobe_d, tx_valid_d, rx_ready_d;
  logic          snap, enter_resp, rx_fire, tx_fire;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;

  assign regIn0 = reg_in[0];
  assign regIn1 = reg_in[1];
  assign regIn2 = reg_in[2];
  assign regIn3 = reg_in[3];
  assign regIn4 = reg_in[4];
  assign regIn5 = reg_in[5];
  assign regIn6 = reg_in[6];
  assign regIn7 = reg_in[7];

  always_comb begin
    reg_out[0] = regOut0;
    reg_out[1] = regOut1;
    reg_out[2] = regOut2;
    reg_out[3] = regOut3;
    reg_out[4] = regOut4;
    reg_out[5] = regOut5;
    reg_out[6] = regOut6;
    reg_out[7] = regOut7;
  end

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_d    = state;
    opcode_d   = opcode;
    idx_d      = idx;
    cnt_d      = cnt;
    tx_idx_d   = tx_idx;
    resp_d     = resp;
    reg_in_d   = reg_in;
    command_d  = command;
    strobe_d   = 1'b0;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    snap       = 1'b0;
    enter_resp = 1'b0;
    hdr        = RESP_OK;

    case (state)
      IDLE: begin
        if (rx_fire && rx_data == SYNC_BYTE) state_d = GET_OP;
      end
      GET_OP: begin
        if (rx_fire) begin
          opcode_d = rx_data;
          idx_d    = '0;
          state_d  = GET_ARG;
        end
      end
      GET_ARG: begin
        if (rx_fire) begin
          reg_in_d[idx] = rx_data;
          idx_d         = idx + 3'd1;
          if (idx == 3'd7) begin
            if (opcode == NOP_OP) begin
              snap       = 1'b1;
              enter_resp = 1'b1;
            end else begin
              state_d   = STROBE;
              command_d = opcode;
              strobe_d  = 1'b1;
            end
          end
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Ack wins over a timeout landing on the same cycle.
        if (status[3]) begin
          snap      = 1'b1;
          state_d   = ACK_STROBE;
          command_d = ACK_CMD;
          strobe_d  = 1'b1;
        end else if (cnt + CW'(1) == CW'(ACK_TIMEOUT)) begin
          snap       = 1'b1;
          hdr        = RESP_TMO;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ACK_STROBE: begin
        enter_resp = 1'b1;
      end
      RESP: begin
        if (tx_fire) begin
          if (tx_idx == 4'(NRESP - 1)) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end else begin
            tx_idx_d  = tx_idx + 4'd1;
            tx_data_d = resp[tx_idx + 4'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (snap) begin
      resp_d[0] = hdr;
      resp_d[1] = status;
      for (int i = 0; i < int'(NARG); i++) resp_d[i+2] = reg_out[i];
    end

    // Response header is preloaded so tx_data is valid with tx_valid.
    if (enter_resp) begin
      state_d    = RESP;
      tx_idx_d   = '0;
      tx_valid_d = 1'b1;
      tx_data_d  = resp_d[0];
    end

    rx_ready_d = (state_d == IDLE) || (state_d == GET_OP) || (state_d == GET_ARG);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      opcode        <= '0;
      idx           <= '0;
      cnt           <= '0;
      tx_idx        <= '0;
      command       <= '0;
      commandStrobe <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      rx_ready      <= 1'b0;
      for (int i = 0; i < int'(NRESP); i++) resp[i] <= '0;
      for (int i = 0; i < int'(NARG); i++) reg_in[i] <= '0;
    end else begin
      state         <= state_d;
      opcode        <= opcode_d;
      idx           <= idx_d;
      cnt           <= cnt_d;
      tx_idx        <= tx_idx_d;
      command       <= command_d;
      commandStrobe <= strobe_d;
      tx_data       <= tx_data_d;
      tx_valid      <= tx_valid_d;
      rx_ready      <= rx_ready_d;
      resp          <= resp_d;
      reg_in        <= reg_in_d;
    end
  end

endmodule

// File: tb/tb_host_cmd_hub.sv
// Bench for host_cmd_hub: directed frame table, hand-written reset sequences,
// and randomized frames checked against a frame-level response model.
module tb_host_cmd_hub;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] command;
  logic       commandStrobe;
  logic [7:0] ri [8];
  logic [7:0] ro [8];
  logic [7:0] status;

  int total = 0;
  int bad   = 0;

  host_cmd_hub #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .command(command), .commandStrobe(commandStrobe),
    .regIn0(ri[0]), .regIn1(ri[1]), .regIn2(ri[2]), .regIn3(ri[3]),
    .regIn4(ri[4]), .regIn5(ri[5]), .regIn6(ri[6]), .regIn7(ri[7]),
    .regOut0(ro[0]), .regOut1(ro[1]), .regOut2(ro[2]), .regOut3(ro[3]),
    .regOut4(ro[4]), .regOut5(ro[5]), .regOut6(ro[6]), .regOut7(ro[7]),
    .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ngarb;
    logic [23:0] garb;
    logic [7:0]  op;
    logic [63:0] args;
    int          ack_delay;
    bit          stall;
    bit          dense;
    logic [7:0]  exp_hdr;
    int          exp_ns;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_command"}, 32'(command), 0);
    check({tag, "_strobe"}, 32'(commandStrobe), 0);
    for (int k = 0; k < 8; k++) check({tag, "_regIn"}, 32'(ri[k]), 0);
  endtask

  // Response rules: NOP -> OK, no strobes; ack in time -> OK, two strobes; else TMO.
  function automatic logic [7:0] model_hdr(input logic [7:0] op, input int ack_delay);
    if (op == 8'h00) return 8'h5A;
    if (ack_delay < 1 || ack_delay > int'(TMO)) return 8'hE1;
    return 8'h5A;
  endfunction

  function automatic int model_ns(input logic [7:0] op, input int ack_delay);
    if (op == 8'h00) return 0;
    if (ack_delay < 1 || ack_delay > int'(TMO)) return 1;
    return 2;
  endfunction

  task automatic run_frame(input vec_t v);
    logic [7:0] bytes [$];
    logic [7:0] rsp [$];
    logic [7:0] strb [$];
    logic [7:0] exp_rsp [10];
    logic [7:0] base, prev_data;
    int i, s_cyc, sync_cyc, tx_cyc, stab_err, rxr_err, stall_cnt;
    bit prev_stall;

    base = 8'($urandom) & 8'hF7;
    status = base;
    for (int k = 0; k < 8; k++) ro[k] = 8'($urandom);
    for (int k = 0; k < v.ngarb; k++) bytes.push_back(v.garb[8*k +: 8]);
    bytes.push_back(8'hA5);
    bytes.push_back(v.op);
    for (int k = 0; k < 8; k++) bytes.push_back(v.args[8*k +: 8]);

    i = 0; s_cyc = -1; sync_cyc = -1; tx_cyc = -1;
    stab_err = 0; rxr_err = 0; stall_cnt = 0; prev_stall = 0; prev_data = '0;
    for (int cyc = 0; cyc < 500 && rsp.size() < 10; cyc++) begin
      @(negedge clk);
      if (commandStrobe) begin
        strb.push_back(command);
        if (s_cyc < 0) s_cyc = cyc;
      end
      if (tx_valid && tx_cyc < 0) tx_cyc = cyc;
      if (v.ack_delay > 0 && s_cyc >= 0 && cyc == s_cyc + v.ack_delay) status = base | 8'h08;
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_err++;
      if (tx_valid && rx_ready) rxr_err++;
      if (v.stall && rsp.size() == 3 && stall_cnt < 5) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end else begin
        tx_ready = v.dense ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (tx_valid && tx_ready) rsp.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (i < bytes.size()) begin
        rx_valid = v.dense ? 1'b1 : ($urandom_range(0, 3) != 0);
        rx_data  = bytes[i];
        if (rx_valid && rx_ready) begin
          if (i == v.ngarb) sync_cyc = cyc;
          i++;
        end
      end else begin
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    check("post_tx_valid", 32'(tx_valid), 0);
    check("post_rx_ready", 32'(rx_ready), 1);

    exp_rsp[0] = v.exp_hdr;
    exp_rsp[1] = (v.exp_ns == 2) ? (base | 8'h08) : base;
    for (int k = 0; k < 8; k++) exp_rsp[k+2] = ro[k];

    check("strobe_count", strb.size(), v.exp_ns);
    if (strb.size() >= 1) check("strobe_cmd", 32'(strb[0]), 32'(v.exp_ns > 0 ? v.op : 8'h08));
    if (strb.size() >= 2) check("ack_cmd", 32'(strb[1]), 32'h08);
    check("rsp_count", rsp.size(), 10);
    for (int k = 0; k < rsp.size() && k < 10; k++) check("rsp_byte", 32'(rsp[k]), 32'(exp_rsp[k]));
    for (int k = 0; k < 8; k++) check("regIn", 32'(ri[k]), 32'(v.args[8*k +: 8]));
    check("tx_stable", stab_err, 0);
    check("rx_backpressure", rxr_err, 0);
    if (v.exp_ns == 2) check("ack_to_resp", tx_cyc - s_cyc, v.ack_delay + 2);
    if (v.exp_ns == 1) check("tmo_to_resp", tx_cyc - s_cyc, int'(TMO) + 1);
    if (v.dense && v.exp_ns > 0) check("sync_to_strobe", s_cyc - sync_cyc, 10);
    if (v.dense && v.exp_ns == 0) check("sync_to_resp", tx_cyc - sync_cyc, 10);
    status = base;
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; status = '0;
    for (int k = 0; k < 8; k++) ro[k] = '0;

    tbl[0] = '{ngarb:0, garb:24'h0, op:8'h04, args:64'h00000014_0000006E, ack_delay:3,
               stall:0, dense:1, exp_hdr:8'h5A, exp_ns:2};
    tbl[1] = '{ngarb:3, garb:24'h13FF00, op:8'h01, args:64'h88776655_44332211, ack_delay:2,
               stall:0, dense:1, exp_hdr:8'h5A, exp_ns:2};
    tbl[2] = '{ngarb:0, garb:24'h0, op:8'h03, args:64'h01020304_05060708, ack_delay:-1,
               stall:0, dense:1, exp_hdr:8'hE1, exp_ns:1};
    tbl[3] = '{ngarb:1, garb:24'h000042, op:8'h07, args:64'hDEADBEEF_CAFEF00D, ack_delay:4,
               stall:1, dense:0, exp_hdr:8'h5A, exp_ns:2};
    tbl[4] = '{ngarb:0, garb:24'h0, op:8'h00, args:64'hA5A55A5A_0F0FF0F0, ack_delay:-1,
               stall:0, dense:1, exp_hdr:8'h5A, exp_ns:0};
    tbl[5] = '{ngarb:0, garb:24'h0, op:8'h09, args:64'h11111111_22222222, ack_delay:16,
               stall:0, dense:1, exp_hdr:8'h5A, exp_ns:2};
    tbl[6] = '{ngarb:2, garb:24'h00A4A6, op:8'h08, args:64'h0, ack_delay:1,
               stall:1, dense:1, exp_hdr:8'h5A, exp_ns:2};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    check("release_rx_ready", 32'(rx_ready), 1);

    for (int t = 0; t < 7; t++) run_frame(tbl[t]);

    // Reset after the 5th argument byte, then a normal frame
    begin
      logic [7:0] part [7];
      int n;
      part = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      n = 0;
      for (int cyc = 0; cyc < 50 && n < 7; cyc++) begin
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = part[n];
        if (rx_ready) n++;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      check("partial_regIn4", 32'(ri[4]), 32'h55);
      resetn = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      @(negedge clk);
      check("midreset_hold_rx_ready", 32'(rx_ready), 0);
      resetn = 1'b1;
      @(negedge clk);
      check("midreset_release_rx_ready", 32'(rx_ready), 1);
      run_frame(tbl[0]);
    end

    // Randomized frames against the model
    for (int t = 0; t < 25; t++) begin
      rv.ngarb = $urandom_range(0, 3);
      rv.garb  = 24'($urandom);
      for (int k = 0; k < 3; k++) if (rv.garb[8*k +: 8] == 8'hA5) rv.garb[8*k +: 8] = 8'h00;
      rv.op        = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rv.args      = {32'($urandom), 32'($urandom)};
      rv.ack_delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 14));
      rv.stall     = ($urandom_range(0, 3) == 0);
      rv.dense     = ($urandom_range(0, 1) == 0);
      rv.exp_hdr   = model_hdr(rv.op, rv.ack_delay);
      rv.exp_ns    = model_ns(rv.op, rv.ack_delay);
      run_frame(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_cmd_hub.md
HOST_CMD_HUB -- requirements
Module: host_cmd_hub

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1024: clocks to wait for capture-core ack before abandoning a command.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: request frame start marker.
REQ-003 Parameter RESP_OK, default 8'h5A; RESP_TMO, default 8'hE1: response header bytes.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 rx_data  in  8  host request byte; rx_valid  in  1; rx_ready  out  1 -- byte accepted when rx_valid & rx_ready.
REQ-007 tx_data  out  8  response byte; tx_valid  out  1; tx_ready  in  1 -- byte consumed when tx_valid & tx_ready.
REQ-008 command  out  8  function code to capture core.
REQ-009 commandStrobe  out  1  one-cycle command qualifier.
REQ-010 regIn0..regIn7  out  8 each  argument registers to capture core.
REQ-011 regOut0..regOut7  in  8 each  result registers from capture core.
REQ-012 status  in  8  core status; bit 3 = ack.

Function
REQ-013 Request frame = SYNC_BYTE, opcode, 8 payload bytes (regIn0 first ... regIn7 last); 10 bytes total.
REQ-014 States: IDLE, GET_OP, GET_ARG, STROBE, WAIT_ACK, ACK_STROBE, RESP.
REQ-015 rx_ready SHALL be 1 only in IDLE, GET_OP, GET_ARG; 0 elsewhere.
REQ-016 IDLE: accepted byte == SYNC_BYTE -> GET_OP; any other byte discarded, stay IDLE.
REQ-017 GET_OP: accepted byte latched into opcode register -> GET_ARG, argument index cleared to 0.
REQ-018 GET_ARG: each accepted byte written to regIn[index] on acceptance cycle; index increments; after 8th byte -> STROBE, or -> RESP with RESP_OK directly if opcode == 8'h00 (NOP, no strobe).
REQ-019 regIn0..7 SHALL hold values between frames; changed only by GET_ARG writes or reset.
REQ-020 STROBE: command = opcode, commandStrobe = 1 for exactly one cycle -> WAIT_ACK; timeout counter cleared.
REQ-021 WAIT_ACK: status[3] == 1 -> snapshot status and regOut0..7 into response buffer that cycle -> ACK_STROBE.
REQ-022 WAIT_ACK: counter reaches ACK_TIMEOUT with no ack -> RESP with header RESP_TMO, no ACK strobe issued.
REQ-023 ACK_STROBE: command = 8'h08, commandStrobe = 1 for one cycle -> RESP with header RESP_OK.
REQ-024 commandStrobe SHALL be 0 in all other states; command holds last driven value.
REQ-025 RESP: sends 10 bytes in order: header, status snapshot, regOut0..regOut7 snapshot; for NOP/timeout, snapshot taken on RESP entry.
REQ-026 tx_valid asserted throughout RESP; tx_data stable while tx_valid & ~tx_ready; advance one byte per handshake; after 10th handshake -> IDLE, tx_valid = 0 next cycle.
REQ-027 Request bytes arriving during STROBE..RESP SHALL be back-pressured (rx_ready = 0), never dropped.
REQ-028 Minimum latency: SYNC accept to commandStrobe = 10 cycles (one per byte with rx_valid held high, plus STROBE entry).
REQ-029 Timeout counter width = clog2(ACK_TIMEOUT)+1; no wrap before compare.

Reset
REQ-030 resetn low at a clock edge SHALL, from any state incl. mid-frame or mid-response: state = IDLE, regIn0..7 = 0, command = 8'h00, commandStrobe = 0, tx_valid = 0, tx_data = 0, rx_ready = 0 during reset, index/counter = 0.
REQ-031 First cycle after reset release: rx_ready = 1.

Verification
REQ-032 Frame A5,04,6E,00,00,00,14,00,00,00; ack after 3 cycles -> regIn0=8'h6E, regIn4=8'h14, command=04 strobe 1 cycle, then command=08 strobe 1 cycle, 10 response bytes starting 5A.
REQ-033 Garbage bytes 00,FF,13 then valid frame opcode 01 -> garbage ignored, single strobe with command=01.
REQ-034 Opcode 03, ack never asserted, ACK_TIMEOUT=16 -> after 16 WAIT_ACK cycles response header E1, no 08 strobe.
REQ-035 tx_ready held low 5 cycles mid-response -> tx_data/tx_valid stable, no byte skipped or repeated; rx_ready = 0 throughout.
REQ-036 resetn pulsed low after 5th argument byte -> all outputs per REQ-030; next full frame processed normally.
REQ-037 Opcode 00 frame -> no commandStrobe, response 5A + live status + regOut0..7.
